// File: rtl/clk_divider_multi_pkg.sv
// Shared state encoding, limits and high-phase helper for clk_divider_multi.
// Build option: CLK_DIVIDER_MULTI_DUAL_EDGE_EN shortens odd-ratio posedge high phase for exact 50% duty.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STOPPING = 2'd2
  } ch_state_t;

  localparam int MIN_FACTOR = 2;

  // Posedge-path high-phase length H for ratio af; factors up to 32 bits wide.
  function automatic logic [31:0] high_count(input logic [31:0] af);
`ifdef CLK_DIVIDER_MULTI_DUAL_EDGE_EN
    return af >> 1;
`else
    return (af >> 1) + {31'd0, af[0]};
`endif
  endfunction

endpackage

// File: rtl/clk_divider_multi_if.sv
// Channel bundle for clk_divider_multi: per-channel factors, load/enable requests and divided outputs.
interface clk_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
);

  logic [NUM_CH*WIDTH-1:0] factor;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       active;

  modport master (
    output factor, load, enable,
    input  clk_out, tick, active
  );

  modport slave (
    input  factor, load, enable,
    output clk_out, tick, active
  );

endinterface

// File: rtl/clk_divider_multi_channel.sv
// One divider channel: counter, shadow factor with period-boundary reload, run/stop FSM.
// Build option: CLK_DIVIDER_MULTI_DUAL_EDGE_EN adds a negedge stage for exact 50% duty on odd ratios.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] factor,
  input  logic             load,
  input  logic             enable,
  output logic             clk_out,
  output logic             tick,
  output logic             active
);

  ch_state_t        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] af_q, af_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic [WIDTH-1:0] af_next_period;
  logic [WIDTH-1:0] af_start;
  logic [31:0]      h_full;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= STOPPED;
      cnt_q     <= '0;
      af_q      <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      pos_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      af_q      <= af_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pos_q     <= pos_d;
      tick_q    <= tick_d;
    end
  end

  // A wrap takes the shadow (pre-load value) first; a load in the same cycle then refills it.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    af_d           = af_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    wrap           = (cnt_q == af_q - WIDTH'(1));
    af_next_period = pending_q ? shadow_q : af_q;
    af_start       = load ? factor : af_q;
    unique case (state_q)
      STOPPED: begin
        if (load) begin
          af_d      = factor;
          pending_d = 1'b0;
        end
        if (enable && (af_start >= WIDTH'(MIN_FACTOR))) begin
          state_d = RUNNING;
          cnt_d   = '0;
        end
      end
      RUNNING, STOPPING: begin
        if (wrap) begin
          af_d      = af_next_period;
          pending_d = 1'b0;
          cnt_d     = '0;
          state_d   = (enable && (af_next_period >= WIDTH'(MIN_FACTOR))) ? RUNNING : STOPPED;
        end else begin
          cnt_d   = cnt_q + WIDTH'(1);
          state_d = enable ? RUNNING : STOPPING;
        end
        if (load) begin
          shadow_d  = factor;
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
  end

  always_comb begin
    h_full = high_count(32'(af_d));
    pos_d  = (state_d != STOPPED) && (32'(cnt_d) < h_full);
    tick_d = (state_d != STOPPED) && (cnt_d == '0);
  end

  assign tick   = tick_q;
  assign active = (state_q != STOPPED);

`ifdef CLK_DIVIDER_MULTI_DUAL_EDGE_EN
  logic neg_q;

  // Half-cycle extension of the high phase, only effective for odd ratios.
  always_ff @(negedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out = pos_q | (neg_q & af_q[0]);
`else
  assign clk_out = pos_q;
`endif

endmodule

// File: rtl/clk_divider_multi.sv
// N-channel runtime-programmable integer clock divider; one clk_div_channel per channel.
// Build option: CLK_DIVIDER_MULTI_DUAL_EDGE_EN (exact 50% duty for odd ratios).
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  clk_divider_multi_if.slave   bus
);

  logic [NUM_CH-1:0] clk_out_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] active_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .factor  (bus.factor[c*WIDTH +: WIDTH]),
      .load    (bus.load[c]),
      .enable  (bus.enable[c]),
      .clk_out (clk_out_w[c]),
      .tick    (tick_w[c]),
      .active  (active_w[c])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.active  = active_w;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: directed scenarios plus random load/enable traffic
// against a period-level reference model (honours CLK_DIVIDER_MULTI_DUAL_EDGE_EN).
module tb_clk_divider_multi;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;

  logic clk_in = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  clk_divider_multi_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  clk_divider_multi #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference: each running channel walks through whole periods of m_per cycles.
  int unsigned       m_af   [NUM_CH];
  int unsigned       m_sh   [NUM_CH];
  int unsigned       m_per  [NUM_CH];
  int unsigned       m_idx  [NUM_CH];
  bit                m_pend [NUM_CH];
  bit                m_on   [NUM_CH];
  logic [NUM_CH-1:0] e_hi1  = '0;
  logic [NUM_CH-1:0] e_hi2  = '0;
  logic [NUM_CH-1:0] e_tick = '0;
  logic [NUM_CH-1:0] e_act  = '0;

  // Number of high half-periods of clk_in within one output period of ratio f.
  function automatic int unsigned high_halves(input int unsigned f);
`ifdef CLK_DIVIDER_MULTI_DUAL_EDGE_EN
    return f;
`else
    return f + (f % 2);
`endif
  endfunction

  always @(posedge clk_in or negedge reset_n) begin
    for (int c = 0; c < NUM_CH; c++) begin
      int unsigned f;
      int unsigned hh;
      f = bus.factor[c*WIDTH +: WIDTH];
      if (!reset_n) begin
        m_on[c] = 0; m_af[c] = 0; m_sh[c] = 0; m_pend[c] = 0; m_per[c] = 0; m_idx[c] = 0;
      end else if (!m_on[c]) begin
        if (bus.load[c]) begin
          m_af[c] = f;
          m_pend[c] = 0;
        end
        if (bus.enable[c] && m_af[c] >= 2) begin
          m_on[c] = 1; m_per[c] = m_af[c]; m_idx[c] = 0;
        end
      end else begin
        if (m_idx[c] == m_per[c] - 1) begin
          if (m_pend[c]) begin
            m_af[c] = m_sh[c];
            m_pend[c] = 0;
          end
          if (bus.enable[c] && m_af[c] >= 2) begin
            m_per[c] = m_af[c]; m_idx[c] = 0;
          end else begin
            m_on[c] = 0;
          end
        end else begin
          m_idx[c] = m_idx[c] + 1;
        end
        if (bus.load[c]) begin
          m_sh[c] = f;
          m_pend[c] = 1;
        end
      end
      hh = high_halves(m_per[c]);
      e_act[c]  = m_on[c];
      e_tick[c] = m_on[c] && (m_idx[c] == 0);
      e_hi1[c]  = m_on[c] && (2 * m_idx[c] < hh);
      e_hi2[c]  = m_on[c] && (2 * m_idx[c] + 1 < hh);
    end
  end

  task automatic set_factor(input int c, input int unsigned f, input bit ld);
    bus.factor[c*WIDTH +: WIDTH] = WIDTH'(f);
    bus.load[c] = ld;
  endtask

  task automatic next_edge();
    @(posedge clk_in);
    #1;
    bus.load = '0;
  endtask

  task automatic half_cycle();
    @(negedge clk_in);
    #1;
  endtask

  task automatic restart();
    @(negedge clk_in);
    #1;
    reset_n    = 1'b0;
    bus.enable = '0;
    bus.load   = '0;
    half_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_edge();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== 3'b000) begin
          n_fail++;
          $display("[TB] FAIL reset ch%0d t=%0t got {clk_out,tick,active}=%b expected 000", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]});
        end
      end
    end
    half_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit [3:0] pat;
    pat = 4'b0011;
    restart();
    set_factor(0, 4, 1'b1); set_factor(1, 2, 1'b1); set_factor(2, 7, 1'b1); set_factor(3, 3, 1'b1);
    for (int i = -1; i < 16; i++) begin
      next_edge();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi1[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL basic_rise ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi1[c], e_tick[c], e_act[c]});
        end
      end
      if (i >= 0) begin
        n_checks++;
        if (bus.clk_out[0] !== pat[i % 4] || bus.tick[0] !== (i % 4 == 0)) begin
          n_fail++;
          $display("[TB] FAIL basic_f4_pattern cycle %0d got clk_out=%b tick=%b expected clk_out=%b tick=%b", i, bus.clk_out[0], bus.tick[0], pat[i % 4], (i % 4 == 0));
        end
      end
      half_cycle();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi2[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL basic_fall ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi2[c], e_tick[c], e_act[c]});
        end
      end
      bus.enable = '1;
    end
  endtask

  task automatic test_odd_and_reload();
    int high_halves_seen;
    restart();
    set_factor(0, 5, 1'b1); set_factor(1, 4, 1'b1); set_factor(2, 4, 1'b1); set_factor(3, 9, 1'b1);
    next_edge();
    half_cycle();
    bus.enable = '1;
    high_halves_seen = 0;
    for (int i = 0; i < 30; i++) begin
      next_edge();
      if (i < 5 && bus.clk_out[0] === 1'b1) high_halves_seen++;
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi1[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL odd_reload_rise ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi1[c], e_tick[c], e_act[c]});
        end
      end
      half_cycle();
      if (i < 5 && bus.clk_out[0] === 1'b1) high_halves_seen++;
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi2[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL odd_reload_fall ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi2[c], e_tick[c], e_act[c]});
        end
      end
      if (i == 4) begin
        n_checks++;
`ifdef CLK_DIVIDER_MULTI_DUAL_EDGE_EN
        if (high_halves_seen != 5) begin
`else
        if (high_halves_seen != 6) begin
`endif
          n_fail++;
          $display("[TB] FAIL odd_f5_duty high half-periods got %0d", high_halves_seen);
        end
      end
      // ch1: single reload 4->6 mid-period; ch2: two loads in one period, last (3) wins
      if (i == 1) begin set_factor(1, 6, 1'b1); set_factor(2, 8, 1'b1); end
      if (i == 2) set_factor(2, 3, 1'b1);
      if (i == 3) set_factor(3, 2, 1'b1);
    end
  endtask

  task automatic test_stop_restart();
    restart();
    set_factor(0, 6, 1'b1); set_factor(1, 6, 1'b1); set_factor(2, 5, 1'b1); set_factor(3, 2, 1'b1);
    next_edge();
    half_cycle();
    bus.enable = '1;
    for (int i = 0; i < 26; i++) begin
      next_edge();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi1[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL stop_rise ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi1[c], e_tick[c], e_act[c]});
        end
      end
      half_cycle();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi2[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL stop_fall ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi2[c], e_tick[c], e_act[c]});
        end
      end
      if (i == 1) begin bus.enable[0] = 1'b0; bus.enable[1] = 1'b0; end
      if (i == 3) bus.enable[1] = 1'b1;
      if (i == 9) bus.enable[0] = 1'b1;
      if (i == 12) bus.enable[3] = 1'b0;
      if (i == 14) bus.enable[3] = 1'b1;
    end
  endtask

  task automatic test_illegal_factor();
    restart();
    set_factor(0, 0, 1'b1); set_factor(1, 1, 1'b1); set_factor(2, 2, 1'b1); set_factor(3, 65535, 1'b1);
    next_edge();
    half_cycle();
    bus.enable = '1;
    for (int i = 0; i < 10; i++) begin
      next_edge();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi1[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL illegal_rise ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi1[c], e_tick[c], e_act[c]});
        end
      end
      half_cycle();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi2[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL illegal_fall ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi2[c], e_tick[c], e_act[c]});
        end
      end
      if (i == 3) set_factor(2, 1, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int c = 0; c < NUM_CH; c++) set_factor(c, 4 + c, 1'b1);
    next_edge();
    half_cycle();
    bus.enable = '1;
    next_edge();
    n_checks++;
    if (bus.clk_out !== e_hi1 || e_hi1 !== '1) begin
      n_fail++;
      $display("[TB] FAIL async_reset_pre got clk_out=%b expected %b", bus.clk_out, 4'b1111);
    end
    #2;
    reset_n = 1'b0;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL async_reset ch%0d t=%0t got %b expected 000", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]});
      end
    end
    half_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < NUM_CH; c++) set_factor(c, $urandom_range(9, 2), 1'b1);
    bus.enable = NUM_CH'($urandom);
    for (int i = 0; i < 600; i++) begin
      next_edge();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi1[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL random_rise ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi1[c], e_tick[c], e_act[c]});
        end
      end
      half_cycle();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if ({bus.clk_out[c], bus.tick[c], bus.active[c]} !== {e_hi2[c], e_tick[c], e_act[c]}) begin
          n_fail++;
          $display("[TB] FAIL random_fall ch%0d t=%0t got %b expected %b", c, $time, {bus.clk_out[c], bus.tick[c], bus.active[c]}, {e_hi2[c], e_tick[c], e_act[c]});
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(9, 0) == 0) bus.enable[c] = ~bus.enable[c];
        if ($urandom_range(5, 0) == 0) set_factor(c, $urandom_range(9, 0), 1'b1);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.factor = '0;
    bus.load   = '0;
    bus.enable = '0;
    test_reset();
    test_basic();
    test_odd_and_reload();
    test_stop_restart();
    test_illegal_factor();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
